// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control-side bundle of the RV523 phase sequencer.
// The control unit drives START/STALL/ABORT (master); the sequencer drives
// the decoded phase enables and status pulses back (slave).
interface phase_sequencer_if #(
   parameter int NPHASE = 3,
   parameter int IW     = 3
);
   logic              START;
   logic              STALL;
   logic              ABORT;
   logic [NPHASE-1:0] PH;
   logic [IW-1:0]     PHIDX;
   logic              BUSY;
   logic              DONE;
   logic              ERR;

   modport master (
      output START, STALL, ABORT,
      input  PH, PHIDX, BUSY, DONE, ERR
   );

   modport slave (
      input  START, STALL, ABORT,
      output PH, PHIDX, BUSY, DONE, ERR
   );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: expands one START request into NPHASE one-hot phase
// enables for the RV523 multi-cycle datapath, then pulses DONE.
// STALL freezes the current phase, ABORT drops the sequence without DONE,
// and a START seen while busy is dropped and flagged on ERR.
// Optional build macro RV523_PHASE_GAP_EN inserts a one-cycle all-zero GAP
// between consecutive phases so adjacent enables never touch.
// Every output comes straight from a flop.
module phase_sequencer #(
   parameter int NPHASE = 3,
   parameter int IW     = 3
) (
   input logic              CLK,
   input logic              RST_N,
   phase_sequencer_if.slave bus
);

   // Sequencer states (legacy-compatible encoding)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
`ifdef RV523_PHASE_GAP_EN
   localparam logic [1:0] ST_GAP  = 2'd3;
`endif

   localparam logic [IW-1:0] LAST_IDX = IW'(NPHASE - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   logic [1:0]        state_q, state_d;
   logic [NPHASE-1:0] ph_q,    ph_d;
   logic [IW-1:0]     phidx_q, phidx_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;

   // Decode a phase index into its one-hot enable; out-of-range gives zero
   function automatic logic [NPHASE-1:0] idx_to_onehot(input logic [IW-1:0] idx);
      logic [NPHASE-1:0] oh;
      oh = '0;
      for (int i = 0; i < NPHASE; i++) begin
         oh[i] = (idx == IW'(i));
      end
      return oh;
   endfunction

   // Next-state and next-output computation for the sequencer
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      phidx_d = phidx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // STALL and ABORT are meaningless here; only START matters
            if (bus.START) begin
               state_d = ST_RUN;
               ph_d    = idx_to_onehot({IW{1'b0}});
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
               ph_d    = '0;
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b0;
            end
         end

         ST_RUN: begin
            // A START while busy is dropped but reported, even alongside ABORT
            err_d = bus.START;
            if (bus.ABORT) begin
               state_d = ST_IDLE;
               ph_d    = '0;
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b0;
            end else if (bus.STALL) begin
               state_d = ST_RUN;
            end else if (phidx_q == LAST_IDX) begin
               // Last phase complete: no gap, straight to the DONE pulse
               state_d = ST_DONE;
               ph_d    = '0;
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
`ifdef RV523_PHASE_GAP_EN
               // Break-before-make: enables drop, index remembers where we were
               state_d = ST_GAP;
               ph_d    = '0;
               phidx_d = phidx_q;
               busy_d  = 1'b1;
`else
               state_d = ST_RUN;
               ph_d    = idx_to_onehot(phidx_q + IDX_ONE);
               phidx_d = phidx_q + IDX_ONE;
               busy_d  = 1'b1;
`endif
            end
         end

`ifdef RV523_PHASE_GAP_EN
         ST_GAP: begin
            err_d = bus.START;
            if (bus.ABORT) begin
               state_d = ST_IDLE;
               ph_d    = '0;
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b0;
            end else if (bus.STALL) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_RUN;
               ph_d    = idx_to_onehot(phidx_q + IDX_ONE);
               phidx_d = phidx_q + IDX_ONE;
               busy_d  = 1'b1;
            end
         end
`endif

         ST_DONE: begin
            // Back-to-back sequences restart without an idle bubble
            if (bus.START) begin
               state_d = ST_RUN;
               ph_d    = idx_to_onehot({IW{1'b0}});
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
               ph_d    = '0;
               phidx_d = {IW{1'b0}};
               busy_d  = 1'b0;
            end
         end

         default: begin
            // Unreachable encoding: recover to a safe idle
            state_d = ST_IDLE;
            ph_d    = '0;
            phidx_d = {IW{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared immediately by the async reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         phidx_q <= {IW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         phidx_q <= phidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.PH    = ph_q;
   assign bus.PHIDX = phidx_q;
   assign bus.BUSY  = busy_q;
   assign bus.DONE  = done_q;
   assign bus.ERR   = err_q;

endmodule
